// File: rtl/nios_timer_host.sv
// nios_timer_host: Avalon-MM initiator that programs the interval timer and services its IRQ.
// Define NIOS_TIMER_HOST_SNAPSHOT_EN to add a counter snapshot after every service.
module nios_timer_host #(
  parameter logic [31:0] PERIOD = 32'h1DCD64FF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        stop,
  input  logic [31:0] period_in,
  output logic [2:0]  address,
  output logic        chipselect,
  output logic        write_n,
  output logic [15:0] writedata,
  input  logic [15:0] readdata,
  input  logic        irq,
  output logic        busy,
  output logic        running,
  output logic        tick,
  output logic [15:0] tick_count,
`ifdef NIOS_TIMER_HOST_SNAPSHOT_EN
  output logic [31:0] snap_value,
`endif
  output logic [3:0]  state_dbg
);

  // Bus handshake: an access is one cycle with chipselect=1; write_n=0 marks a write.
  // There is no waitrequest, and readdata is valid the cycle after the read address.
  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_WR_PL   = 4'd1;
  localparam logic [3:0] S_WR_PH   = 4'd2;
  localparam logic [3:0] S_WR_CTRL = 4'd3;
  localparam logic [3:0] S_RUN     = 4'd4;
  localparam logic [3:0] S_CLR     = 4'd5;
  localparam logic [3:0] S_WR_STOP = 4'd6;
`ifdef NIOS_TIMER_HOST_SNAPSHOT_EN
  localparam logic [3:0] S_SNAP_W    = 4'd7;
  localparam logic [3:0] S_SNAP_RL   = 4'd8;
  localparam logic [3:0] S_SNAP_RH   = 4'd9;
  localparam logic [3:0] S_SNAP_DONE = 4'd10;
`endif

  logic [3:0]  state_q, state_d;
  logic [31:0] period_q, period_d;
  logic        stop_pend_q, stop_pend_d;
  logic [15:0] tick_count_q, tick_count_d;
  logic        svc_state;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start) state_d = S_WR_PL;
      S_WR_PL:   state_d = S_WR_PH;
      S_WR_PH:   state_d = S_WR_CTRL;
      S_WR_CTRL: state_d = S_RUN;
      S_RUN: begin
        if (stop_pend_q) state_d = S_WR_STOP;
        else if (irq)    state_d = S_CLR;
      end
`ifdef NIOS_TIMER_HOST_SNAPSHOT_EN
      S_CLR:       state_d = S_SNAP_W;
      S_SNAP_W:    state_d = S_SNAP_RL;
      S_SNAP_RL:   state_d = S_SNAP_RH;
      S_SNAP_RH:   state_d = S_SNAP_DONE;
      S_SNAP_DONE: state_d = S_RUN;
`else
      S_CLR:       state_d = S_RUN;
`endif
      S_WR_STOP: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    period_d = period_q;
    if (state_q == S_IDLE && start) period_d = (period_in == 32'd0) ? PERIOD : period_in;
  end

  // A stop seen in IDLE is dropped; the clear in WR_STOP wins over a new pulse.
  always_comb begin
    stop_pend_d = stop_pend_q;
    if (state_q == S_WR_STOP)                 stop_pend_d = 1'b0;
    else if (stop && state_q != S_IDLE)       stop_pend_d = 1'b1;
  end

  always_comb begin
    tick_count_d = tick_count_q;
    if (state_q == S_CLR) tick_count_d = tick_count_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      period_q     <= 32'd0;
      stop_pend_q  <= 1'b0;
      tick_count_q <= 16'd0;
    end else begin
      state_q      <= state_d;
      period_q     <= period_d;
      stop_pend_q  <= stop_pend_d;
      tick_count_q <= tick_count_d;
    end
  end

  always_comb begin
    address    = 3'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 16'd0;
    case (state_q)
      S_WR_PL: begin
        chipselect = 1'b1; write_n = 1'b0; address = 3'd2; writedata = period_q[15:0];
      end
      S_WR_PH: begin
        chipselect = 1'b1; write_n = 1'b0; address = 3'd3; writedata = period_q[31:16];
      end
      S_WR_CTRL: begin
        chipselect = 1'b1; write_n = 1'b0; address = 3'd1; writedata = 16'h0007;
      end
      S_CLR: begin
        chipselect = 1'b1; write_n = 1'b0; address = 3'd0; writedata = 16'h0000;
      end
      S_WR_STOP: begin
        chipselect = 1'b1; write_n = 1'b0; address = 3'd1; writedata = 16'h0008;
      end
`ifdef NIOS_TIMER_HOST_SNAPSHOT_EN
      S_SNAP_W: begin
        chipselect = 1'b1; write_n = 1'b0; address = 3'd4; writedata = 16'h0000;
      end
      S_SNAP_RL: begin
        chipselect = 1'b1; address = 3'd4;
      end
      S_SNAP_RH: begin
        chipselect = 1'b1; address = 3'd5;
      end
`endif
      default: ;
    endcase
  end

`ifdef NIOS_TIMER_HOST_SNAPSHOT_EN
  logic [31:0] snap_q, snap_d;

  // Low half arrives in SNAP_RH (read of addr 4), high half in SNAP_DONE.
  always_comb begin
    snap_d = snap_q;
    if (state_q == S_SNAP_RH)   snap_d[15:0]  = readdata;
    if (state_q == S_SNAP_DONE) snap_d[31:16] = readdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) snap_q <= 32'd0;
    else          snap_q <= snap_d;
  end

  assign snap_value = snap_q;
  assign svc_state  = (state_q == S_CLR) || (state_q == S_SNAP_W) || (state_q == S_SNAP_RL) ||
                      (state_q == S_SNAP_RH) || (state_q == S_SNAP_DONE);
`else
  logic unused_readdata;
  assign unused_readdata = ^readdata;
  assign svc_state       = (state_q == S_CLR);
`endif

  assign busy       = (state_q != S_IDLE) && (state_q != S_RUN);
  assign running    = (state_q == S_RUN) || svc_state;
  assign tick       = (state_q == S_CLR);
  assign tick_count = tick_count_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_nios_timer_host.sv
// Bench for nios_timer_host: behavioural interval-timer slave plus scenario tasks.
`timescale 1ns/1ps
module tb_nios_timer_host;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [31:0] period_in = 32'd0;
  logic [2:0]  address;
  logic        chipselect, write_n;
  logic [15:0] writedata;
  logic [15:0] readdata;
  logic        irq;
  logic        busy, running, tick;
  logic [15:0] tick_count;
  logic [3:0]  state_dbg;
`ifdef NIOS_TIMER_HOST_SNAPSHOT_EN
  logic [31:0] snap_value;
  localparam int SVC = 5;
`else
  localparam int SVC = 1;
`endif

  int          total = 0;
  int          bad = 0;
  logic [15:0] exp_count = 16'd0;
  logic [18:0] exp_q[$];
  logic        use_model = 1'b1;
  logic        man_irq = 1'b0;

  always #5 clk = ~clk;

  nios_timer_host dut (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .period_in(period_in),
    .address(address), .chipselect(chipselect), .write_n(write_n), .writedata(writedata),
    .readdata(readdata), .irq(irq), .busy(busy), .running(running), .tick(tick),
    .tick_count(tick_count),
`ifdef NIOS_TIMER_HOST_SNAPSHOT_EN
    .snap_value(snap_value),
`endif
    .state_dbg(state_dbg)
  );

  // Interval timer slave: continuous count of period+1 clocks, clear beats a coincident timeout.
  logic [31:0] t_period, t_cnt, t_snap;
  logic        t_run, t_to, t_ito;
  logic [15:0] t_rdata;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      t_period <= 32'd0; t_cnt <= 32'd0; t_snap <= 32'd0;
      t_run <= 1'b0; t_to <= 1'b0; t_ito <= 1'b0; t_rdata <= 16'd0;
    end else begin
      if (t_run) begin
        if (t_cnt == 32'd0) begin t_cnt <= t_period; t_to <= 1'b1; end
        else t_cnt <= t_cnt - 32'd1;
      end
      if (chipselect && !write_n) begin
        case (address)
          3'd0: t_to <= 1'b0;
          3'd1: begin
            t_ito <= writedata[0];
            if (writedata[2]) begin t_run <= 1'b1; t_cnt <= t_period; end
            if (writedata[3]) t_run <= 1'b0;
          end
          3'd2: t_period[15:0]  <= writedata;
          3'd3: t_period[31:16] <= writedata;
          3'd4: t_snap <= t_cnt;
          default: ;
        endcase
      end
      if (chipselect && write_n)
        t_rdata <= (address == 3'd4) ? t_snap[15:0] : (address == 3'd5) ? t_snap[31:16] : 16'd0;
    end
  end
  assign readdata = t_rdata;
  assign irq      = use_model ? (t_to & t_ito) : man_irq;

  // Idle bus must be fully parked.
  always @(negedge clk) begin
    if (chipselect === 1'b0) begin
      total++;
      if ({address, write_n, writedata} !== {3'd0, 1'b1, 16'd0}) begin
        bad++;
        $display("FAIL idle_bus got addr=%0d wn=%b wd=%h want 0/1/0000", address, write_n, writedata);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; stop = 1'b0;
    #1;
    total++;
    if ({address, chipselect, write_n, writedata} !== {3'd0, 1'b0, 1'b1, 16'd0}) begin
      bad++;
      $display("FAIL reset_bus got a=%0d cs=%b wn=%b wd=%h want 0/0/1/0000", address, chipselect, write_n, writedata);
    end
    total++;
    if ({busy, running, tick} !== 3'b000) begin
      bad++; $display("FAIL reset_flags got busy/run/tick=%b%b%b want 000", busy, running, tick);
    end
    total++;
    if (tick_count !== 16'd0) begin
      bad++; $display("FAIL reset_count got %h want 0000", tick_count);
    end
`ifdef NIOS_TIMER_HOST_SNAPSHOT_EN
    total++;
    if (snap_value !== 32'd0) begin
      bad++; $display("FAIL reset_snap got %h want 0", snap_value);
    end
`endif
    exp_count = 16'd0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic do_stop();
    int n = 0;
    stop = 1'b1; @(negedge clk); stop = 1'b0;
    while (!(chipselect === 1'b1 && write_n === 1'b0 && address === 3'd1) && n < 12) begin
      @(negedge clk); n++;
    end
    total++;
    if (n >= 12 || writedata !== 16'h0008) begin
      bad++; $display("FAIL stop_write got wd=%h after %0d cycles want 0008", writedata, n);
    end
    @(negedge clk);
    total++;
    if ({busy, running} !== 2'b00) begin
      bad++; $display("FAIL stop_idle got busy/run=%b%b want 00", busy, running);
    end
  endtask

  task automatic test_start_default();
    logic [18:0] e;
    stop = 1'b1; @(negedge clk); stop = 1'b0;
    exp_q = {};
    exp_q.push_back({3'd2, 16'h64FF});
    exp_q.push_back({3'd3, 16'h1DCD});
    exp_q.push_back({3'd1, 16'h0007});
    period_in = 32'd0; start = 1'b1; @(negedge clk); start = 1'b0;
    period_in = $urandom;
    for (int i = 0; i < 3; i++) begin
      e = exp_q.pop_front();
      total++;
      if ({chipselect, write_n} !== 2'b10 || {address, writedata} !== e) begin
        bad++;
        $display("FAIL setup_write%0d got cs=%b wn=%b a=%0d wd=%h want a=%0d wd=%h",
                 i, chipselect, write_n, address, writedata, e[18:16], e[15:0]);
      end
      total++;
      if (busy !== 1'b1) begin bad++; $display("FAIL setup_busy%0d got %b want 1", i, busy); end
      @(negedge clk);
    end
    total++;
    if ({busy, running} !== 2'b01) begin
      bad++; $display("FAIL run_entry got busy/run=%b%b want 01", busy, running);
    end
    repeat (3) @(negedge clk);
    total++;
    if (running !== 1'b1) begin
      bad++; $display("FAIL idle_stop_discard got running=%b want 1", running);
    end
    do_stop();
  endtask

  task automatic test_ticks(input int p);
    int cyc = 0, last = -1, nt = 0, busy_cyc = 0, snap_due = -1;
    int limit;
    limit = 30 * (p + 1) + 100;
    period_in = p; start = 1'b1; @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({busy, running} !== 2'b01) begin
      bad++; $display("FAIL ticks_run p=%0d got busy/run=%b%b want 01", p, busy, running);
    end
    while (cyc < limit && !(nt == 5 && cyc >= last + 6)) begin
      @(negedge clk); cyc++;
      if (busy) busy_cyc++;
      if (tick) begin
        exp_count++;
        if (last >= 0) begin
          total++;
          if (cyc - last != p + 1) begin
            bad++; $display("FAIL tick_interval p=%0d got %0d want %0d", p, cyc - last, p + 1);
          end
        end
        last = cyc; nt++; snap_due = cyc + 5;
        total++;
        if ({address, chipselect, write_n, writedata} !== {3'd0, 1'b1, 1'b0, 16'h0000}) begin
          bad++; $display("FAIL clr_write got a=%0d cs=%b wn=%b wd=%h want 0/1/0/0000", address, chipselect, write_n, writedata);
        end
      end
`ifdef NIOS_TIMER_HOST_SNAPSHOT_EN
      if (cyc == snap_due) begin
        total++;
        if (snap_value !== t_snap || snap_value > p || snap_value + 6 < p) begin
          bad++; $display("FAIL snap p=%0d got %0d want %0d in %0d..%0d", p, snap_value, t_snap, p - 6, p);
        end
      end
`endif
    end
    total++;
    if (nt != 5) begin bad++; $display("FAIL tick_timeout p=%0d got %0d ticks want 5", p, nt); end
    total++;
    if (busy_cyc != 5 * SVC) begin
      bad++; $display("FAIL service_len p=%0d got %0d busy cycles want %0d", p, busy_cyc, 5 * SVC);
    end
    total++;
    if (tick_count !== exp_count) begin
      bad++; $display("FAIL tick_count p=%0d got %h want %h", p, tick_count, exp_count);
    end
    do_stop();
  endtask

  task automatic test_stop_mid_setup();
    logic [20:0] tbl [6];
    int          p;
    p = $urandom_range(200, 1000);
    tbl[0] = {1'b1, 1'b0, 3'd2, p[15:0]};
    tbl[1] = {1'b1, 1'b0, 3'd3, p[31:16]};
    tbl[2] = {1'b1, 1'b0, 3'd1, 16'h0007};
    tbl[3] = {1'b0, 1'b1, 3'd0, 16'h0000};
    tbl[4] = {1'b1, 1'b0, 3'd1, 16'h0008};
    tbl[5] = {1'b0, 1'b1, 3'd0, 16'h0000};
    period_in = p; start = 1'b1; @(negedge clk); start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      stop = (i == 1);
      total++;
      if ({chipselect, write_n, address, writedata} !== tbl[i]) begin
        bad++;
        $display("FAIL stop_seq%0d got cs=%b wn=%b a=%0d wd=%h want cs=%b wn=%b a=%0d wd=%h", i,
                 chipselect, write_n, address, writedata, tbl[i][20], tbl[i][19], tbl[i][18:16], tbl[i][15:0]);
      end
      if (i == 3) begin
        total++;
        if (running !== 1'b1) begin bad++; $display("FAIL stop_run got running=%b want 1", running); end
      end
      @(negedge clk);
    end
    stop = 1'b0;
    total++;
    if ({busy, running} !== 2'b00) begin
      bad++; $display("FAIL stop_end got busy/run=%b%b want 00", busy, running);
    end
  endtask

  task automatic test_wrap();
    int n;
    use_model = 1'b0; man_irq = 1'b0;
    force dut.tick_count_q = 16'hFFFD;
    @(negedge clk);
    release dut.tick_count_q;
    exp_count = 16'hFFFD;
    period_in = 32'd0; start = 1'b1; @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      man_irq = 1'b1; n = 0;
      while (tick !== 1'b1 && n < 10) begin @(negedge clk); n++; end
      man_irq = 1'b0;
      exp_count++;
      total++;
      if (tick !== 1'b1) begin bad++; $display("FAIL wrap_tick%0d got tick=%b want 1", k, tick); end
      repeat (SVC) @(negedge clk);
      total++;
      if (tick_count !== exp_count) begin
        bad++; $display("FAIL wrap_count%0d got %h want %h", k, tick_count, exp_count);
      end
    end
    do_stop();
    use_model = 1'b1;
  endtask

  task automatic test_reset_mid();
    int n = 0;
    period_in = $urandom_range(15, 30); start = 1'b1; @(negedge clk); start = 1'b0;
`ifdef NIOS_TIMER_HOST_SNAPSHOT_EN
    while (!(chipselect === 1'b1 && write_n === 1'b1 && address === 3'd4) && n < 200) begin
`else
    while (tick !== 1'b1 && n < 200) begin
`endif
      @(negedge clk); n++;
    end
    total++;
    if (n >= 200) begin bad++; $display("FAIL reset_mid_trigger got timeout want service"); end
    test_reset();
    period_in = 32'd0; start = 1'b1; @(negedge clk); start = 1'b0;
    total++;
    if ({chipselect, write_n, address, writedata} !== {1'b1, 1'b0, 3'd2, 16'h64FF}) begin
      bad++; $display("FAIL restart got cs=%b wn=%b a=%0d wd=%h want 1/0/2/64ff", chipselect, write_n, address, writedata);
    end
    repeat (3) @(negedge clk);
    do_stop();
  endtask

  initial begin
    test_reset();
    test_start_default();
    test_ticks(9);
    test_ticks(99);
    test_ticks($urandom_range(12, 40));
    test_stop_mid_setup();
    test_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
